hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised hazard unit for the ARM-style pipeline. It replaces the fixed EX/MEM hazard compare with an
//  in-flight scoreboard: a shift register of PIPE_DEPTH records {valid, dest, wb_en, is_load}.
//  Each cycle it checks up to NUM_SRC decode-stage source registers against the scoreboard.
//  It produces the ID stall, per-source forward selects and a stall-cycle counter.
// PARAMETERS
//  REG_ADDR_W  4   register address width
//  NUM_SRC     3   source operands checked per decode instruction (rn, rm, rs)
//  PIPE_DEPTH  3   tracked in-flight stages; stage 0 = instruction directly ahead of ID
//  LOAD_LAT    1   stages a load record must pass before its data is forwardable (1..PIPE_DEPTH-1)
//  SEL_W       2   fwd_sel field width, must satisfy 2**SEL_W > PIPE_DEPTH
// PORTS
//  clk          in   1                   clock, rising edge
//  rst          in   1                   asynchronous, active-low reset
//  id_valid     in   1                   decode slot holds a real instruction
//  id_src       in   NUM_SRC*REG_ADDR_W  source regs; field i = [i*REG_ADDR_W +: REG_ADDR_W]
//  id_src_used  in   NUM_SRC             bit i: source i is actually read
//  id_dest      in   REG_ADDR_W          decode destination register
//  id_wb_en     in   1                   decode instruction writes id_dest
//  id_mem_read  in   1                   decode instruction is a load
//  pipe_adv     in   1                   pipeline advances this cycle (0 = global freeze)
//  flush        in   1                   branch taken: kill decode slot and stage-0 record
//  stall        out  1                   hold PC/IF/ID, inject bubble (combinational)
//  fwd_sel      out  NUM_SRC*SEL_W       per source: 0 = regfile, k = forward from record stage k-1
//  stall_cnt    out  16                  saturating count of stalled, advancing cycles
// BEHAVIOUR
//  - Reset (rst=0, async): all record valid bits 0, stall_cnt 0. With reset inputs this gives stall 0, fwd_sel 0.
//  - Match(i,s): id_valid & id_src_used[i] & rec[s].valid & rec[s].wb_en & id_src[i]==rec[s].dest.
//  - Per source, only the youngest matching stage (lowest s) counts; older matches are ignored.
//  - Forward/stall rule per source i, youngest match at stage s:
//      - rec[s].is_load & s < LOAD_LAT -> stall=1, fwd_sel[i]=0.
//      - otherwise -> fwd_sel[i]=s+1.
//      - no match -> fwd_sel[i]=0.
//  - stall = OR over sources of the stall condition. It is combinational, with no registered latency.
//  - Scoreboard update at posedge when pipe_adv=1:
//      - rec[s+1] <= rec[s] for s = 0..PIPE_DEPTH-2. Record PIPE_DEPTH-1 retires.
//      - rec[0] <= {id_valid & ~stall & ~flush, id_dest, id_wb_en, id_mem_read}.
//      - Stall and flush therefore insert a bubble.
//  - flush & pipe_adv: the stage-0 record is not shifted into stage 1 (it becomes invalid there), and the new
//    rec[0] is a bubble. Older records are unaffected.
//  - pipe_adv=0: all records hold, and stall/fwd_sel still track the current inputs. stall_cnt holds.
//  - stall_cnt increments at posedge when stall & pipe_adv. It saturates at 16'hFFFF; no wrap.
//  - Simultaneous stall and flush: flush wins; a bubble is inserted and stall_cnt still counts if stall=1.
//  - Decode instruction with wb_en=0: its record is valid but never matches.
//  - An id_dest equal to its own id_src does not self-hazard.
//  - Reset mid-operation: all in-flight records are discarded immediately. There is no pending stall after
//    rst deasserts.
// CONFIGURATION
//  - FORWARDING_EN defined: forward/stall rules as above.
//  - FORWARDING_EN undefined: no forwarding. fwd_sel tied to 0.
//    stall = 1 on any Match(i,s) for any source and any stage, whether or not the record is a load.
//    The scoreboard and stall_cnt behave identically.
// TESTING
//  Defaults, FORWARDING_EN defined unless stated otherwise.
//  1. Reset: hold rst=0 with random inputs for 3 cycles, then release -> stall=0, fwd_sel=0, stall_cnt=0.
//  2. ALU chain:
//     - Stimulus: ADD r1 issued, next decode reads r1 in src0.
//     - Required: stall=0, fwd_sel[0]=1. One cycle later with an unrelated decode instruction, a read of r1
//       gives fwd_sel[0]=2.
//  3. Load-use:
//     - Stimulus: LDR r2 issued, next decode reads r2.
//     - Required: stall=1 for exactly 1 cycle, then fwd_sel=2, stall_cnt=1.
//  4. Youngest wins:
//     - Stimulus: r3 is written by stages 0 and 2.
//     - Required: fwd_sel=1.
//     - Stimulus: src_used=0 for that source.
//     - Required: fwd_sel=0, stall=0.
//  5. Flush/freeze:
//     - Stimulus: LDR r4 then flush=1 on the same edge.
//     - Required: a decode read of r4 next cycle gives stall=0, fwd_sel=0.
//     - Stimulus: pipe_adv=0 for 4 cycles.
//     - Required: records hold, stall_cnt unchanged.
//  6. FORWARDING_EN undefined:
//     - Stimulus: ADD r5, then decode reads r5.
//     - Required: stall=1 for 3 cycles (PIPE_DEPTH), fwd_sel=0 throughout, stall_cnt=3.

Source files
------------

// File: rtl/hazard_scoreboard_unit_if.sv
// Decode-side bundle for the hazard scoreboard: decode operands, pipeline
// control in; stall, forward selects and stall counter out.
interface hazard_scoreboard_unit_if #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int SEL_W      = 2
);
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]         id_dest;
    logic                          id_wb_en;
    logic                          id_mem_read;
    logic                          pipe_adv;
    logic                          flush;
    logic                          stall;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic [15:0]                   stall_cnt;

    modport master (
        output id_valid, id_src, id_src_used, id_dest,
        output id_wb_en, id_mem_read, pipe_adv, flush,
        input  stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dest,
        input  id_wb_en, id_mem_read, pipe_adv, flush,
        output stall, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// In-flight scoreboard hazard unit: youngest-match forwarding/stall per source.
// Ports: clk, rst (async active-low), bus (slave: decode in, stall/fwd_sel/stall_cnt out).
// Macro FORWARDING_EN: when defined, forward from records; otherwise stall on any match.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 2
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_unit_if.slave bus
);

    logic [PIPE_DEPTH-1:0]                 vld_q;
    logic [PIPE_DEPTH-1:0]                 wb_q;
    logic [PIPE_DEPTH-1:0]                 ld_q;
    logic [PIPE_DEPTH-1:0][REG_ADDR_W-1:0] dst_q;
    logic [15:0]                           cnt_q;
    logic [15:0]                           cnt_d;

    logic                     stall_c;
    logic [NUM_SRC*SEL_W-1:0] fwd_c;
    logic [NUM_SRC-1:0]       hit_c;

    // Stages are scanned youngest first; hit_c locks out older matches.
    always_comb begin
        stall_c = 1'b0;
        fwd_c   = '0;
        hit_c   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                if (!hit_c[i] && bus.id_valid && bus.id_src_used[i] &&
                    vld_q[s] && wb_q[s] &&
                    bus.id_src[i*REG_ADDR_W +: REG_ADDR_W] == dst_q[s]) begin
                    hit_c[i] = 1'b1;
`ifdef FORWARDING_EN
                    if (ld_q[s] && s < LOAD_LAT)
                        stall_c = 1'b1;
                    else
                        fwd_c[i*SEL_W +: SEL_W] = SEL_W'(s + 1);
`else
                    stall_c = 1'b1;
`endif
                end
            end
        end
    end

`ifndef FORWARDING_EN
    // Load flag and latency only matter when forwarding.
    localparam int unused_lat = LOAD_LAT;
    logic unused_ld;
    assign unused_ld = ^ld_q;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (stall_c && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            wb_q  <= '0;
            ld_q  <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else if (bus.pipe_adv) begin
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                // A flush kills the record leaving stage 0.
                vld_q[s] <= (s == 1) ? (vld_q[0] & ~bus.flush)
                                     : vld_q[s-1];
                wb_q[s]  <= wb_q[s-1];
                ld_q[s]  <= ld_q[s-1];
                dst_q[s] <= dst_q[s-1];
            end
            vld_q[0] <= bus.id_valid & ~stall_c & ~bus.flush;
            wb_q[0]  <= bus.id_wb_en;
            ld_q[0]  <= bus.id_mem_read;
            dst_q[0] <= bus.id_dest;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.fwd_sel   = fwd_c;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with a queue of expected outputs.
// Expectations follow the FORWARDING_EN setting of the build.
module tb_hazard_scoreboard_unit;

    typedef struct {
        string       tag;
        logic        stall;
        logic [5:0]  fwd;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] c;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(
        .REG_ADDR_W(4), .NUM_SRC(3), .SEL_W(2)
    ) bus ();

    hazard_scoreboard_unit #(
        .REG_ADDR_W(4), .NUM_SRC(3), .PIPE_DEPTH(3),
        .LOAD_LAT(1), .SEL_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic drive(
        input logic v, input logic [3:0] s0, s1, s2,
        input logic [2:0] used, input logic [3:0] d,
        input logic wb, ld, adv, fl
    );
        bus.id_valid    = v;
        bus.id_src      = {s2, s1, s0};
        bus.id_src_used = used;
        bus.id_dest     = d;
        bus.id_wb_en    = wb;
        bus.id_mem_read = ld;
        bus.pipe_adv    = adv;
        bus.flush       = fl;
    endtask

    task automatic chk();
        exp_t e;
        e = q.pop_front();
        n_tests++;
        assert (bus.stall === e.stall) else begin
            n_fail++;
            $error("FAIL %s stall obs=%0b exp=%0b", e.tag, bus.stall, e.stall);
        end
        n_tests++;
        assert (bus.fwd_sel === e.fwd) else begin
            n_fail++;
            $error("FAIL %s fwd_sel obs=%b exp=%b", e.tag, bus.fwd_sel, e.fwd);
        end
        n_tests++;
        assert (bus.stall_cnt === e.cnt) else begin
            n_fail++;
            $error("FAIL %s stall_cnt obs=%0d exp=%0d", e.tag, bus.stall_cnt, e.cnt);
        end
    endtask

    task automatic cyc(
        input string tag,
        input logic v, input logic [3:0] s0, s1, s2,
        input logic [2:0] used, input logic [3:0] d,
        input logic wb, ld, adv, fl,
        input logic es, input logic [5:0] ef, input logic [15:0] ec
    );
        @(negedge clk);
        drive(v, s0, s1, s2, used, d, wb, ld, adv, fl);
        q.push_back('{tag, es, ef, ec});
        #2;
        chk();
    endtask

    task automatic drain(input logic [15:0] ec);
        for (int k = 0; k < 3; k++)
            cyc("drain", 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 6'b0, ec);
    endtask

    initial begin
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
        // reset held with random decode traffic
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            q.push_back('{"rst_hold", 1'b0, 6'b0, 16'd0});
            #2;
            chk();
        end
        @(negedge clk);
        rst = 1'b1;
        c = 16'd0;
        cyc("rst_rel", 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 6'b0, c);

`ifdef FORWARDING_EN
        cyc("alu_issue", 1, 0, 0, 0, 3'b000, 1, 1, 0, 1, 0, 0, 6'b000000, c);
        cyc("alu_fwd1",  1, 1, 0, 0, 3'b001, 6, 1, 0, 1, 0, 0, 6'b000001, c);
        cyc("alu_fwd2",  1, 1, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0, 6'b000010, c);
        cyc("alu_fwd3",  1, 0, 1, 0, 3'b010, 0, 0, 0, 1, 0, 0, 6'b001100, c);
        cyc("self_dest", 1, 1, 0, 6, 3'b101, 1, 1, 0, 1, 0, 0, 6'b110000, c);
        drain(c);
        cyc("ld_issue", 1, 0, 0, 0, 3'b000, 2, 1, 1, 1, 0, 0, 6'b000000, c);
        cyc("ld_stall", 1, 2, 0, 0, 3'b001, 7, 1, 0, 1, 0, 1, 6'b000000, c);
        c = c + 16'd1;
        cyc("ld_fwd",   1, 2, 0, 0, 3'b001, 7, 1, 0, 1, 0, 0, 6'b000010, c);
        drain(c);
        cyc("y_w1",     1, 0, 0, 0, 3'b000, 3, 1, 0, 1, 0, 0, 6'b000000, c);
        cyc("y_nop",    1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 6'b000000, c);
        cyc("y_w2",     1, 0, 0, 0, 3'b000, 3, 1, 0, 1, 0, 0, 6'b000000, c);
        cyc("y_young",  1, 0, 3, 0, 3'b010, 0, 0, 0, 0, 0, 0, 6'b000100, c);
        cyc("y_unused", 1, 0, 3, 0, 3'b000, 0, 0, 0, 0, 0, 0, 6'b000000, c);
        drain(c);
`else
        cyc("n_issue",  1, 0, 0, 0, 3'b000, 5, 1, 0, 1, 0, 0, 6'b0, c);
        for (int k = 0; k < 3; k++) begin
            cyc("n_stall", 1, 5, 0, 0, 3'b001, 12, 1, 0, 1, 0, 1, 6'b0, c);
            c = c + 16'd1;
        end
        cyc("n_clear",  1, 5, 0, 0, 3'b001, 12, 1, 0, 1, 0, 0, 6'b0, c);
        cyc("n_nowb",   1, 0, 0, 0, 3'b000, 13, 0, 0, 1, 0, 0, 6'b0, c);
        cyc("n_nowb_rd", 1, 13, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0, 6'b0, c);
        drain(c);
`endif

        cyc("f_add",     1, 0, 0, 0, 3'b000, 8, 1, 0, 1, 0, 0, 6'b0, c);
        cyc("f_ldflush", 1, 0, 0, 0, 3'b000, 4, 1, 1, 1, 1, 0, 6'b0, c);
        cyc("f_read",    1, 4, 8, 0, 3'b011, 0, 0, 0, 1, 0, 0, 6'b0, c);
        drain(c);

        cyc("z_ld", 1, 0, 0, 0, 3'b000, 9, 1, 1, 1, 0, 0, 6'b0, c);
        for (int k = 0; k < 4; k++)
            cyc("z_freeze", 1, 9, 0, 0, 3'b001, 0, 0, 0, 0, 0, 1, 6'b0, c);
        cyc("z_adv", 1, 9, 0, 0, 3'b001, 0, 0, 0, 1, 0, 1, 6'b0, c);
        c = c + 16'd1;
`ifdef FORWARDING_EN
        cyc("z_fwd", 1, 9, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0, 6'b000010, c);
`else
        cyc("z_fwd", 1, 9, 0, 0, 3'b001, 0, 0, 0, 1, 0, 1, 6'b0, c);
        c = c + 16'd1;
`endif
        drain(c);

        cyc("s_ld",      1, 0, 0, 0, 3'b000, 10, 1, 1, 1, 0, 0, 6'b0, c);
        cyc("s_stflush", 1, 10, 0, 0, 3'b001, 0, 0, 0, 1, 1, 1, 6'b0, c);
        c = c + 16'd1;
        cyc("s_after",   1, 10, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0, 6'b0, c);

        cyc("r_ld",    1, 0, 0, 0, 3'b000, 11, 1, 1, 1, 0, 0, 6'b0, c);
        cyc("r_stall", 1, 11, 0, 0, 3'b001, 0, 0, 0, 1, 0, 1, 6'b0, c);
        #1 rst = 1'b0;
        #1;
        q.push_back('{"r_mid", 1'b0, 6'b0, 16'd0});
        chk();
        @(negedge clk);
        rst = 1'b1;
        cyc("r_after", 1, 11, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0, 6'b0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
